// File: rtl/bram_ecc_scrubber_if.sv
// BRAM port bundle between the ECC scrubber (master) and the arbitrated cache BRAM (slave).
interface bram_ecc_scrubber_if #(
    parameter int unsigned ADDRMSB = 8
) ();
    logic               req;
    logic               gnt;
    logic [ADDRMSB:0]   mem_addr;
    logic               mem_we;
    logic [127:0]       mem_wdata;
    logic [127:0]       mem_rdata;
    logic               mem_sberr;
    logic               mem_dberr;

    modport master (
        output req,
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  gnt,
        input  mem_rdata,
        input  mem_sberr,
        input  mem_dberr
    );

    modport slave (
        input  req,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output gnt,
        output mem_rdata,
        output mem_sberr,
        output mem_dberr
    );
endinterface

// File: rtl/bram_ecc_scrubber.sv
// Background ECC scrubber: walks every BRAM line, rewrites single-bit errors with the
// corrected data and logs double-bit errors, borrowing the port through a req/gnt arbiter.
module bram_ecc_scrubber #(
    parameter int unsigned ADDRMSB  = 8,
    parameter int unsigned INTERVAL = 1024,
    parameter int unsigned READ_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 clr_counts,
    bram_ecc_scrubber_if.master  bus,
    output logic [15:0]          sb_count,
    output logic [15:0]          db_count,
    output logic [ADDRMSB:0]     db_addr,
    output logic                 db_irq,
    output logic                 pass_done
);

    localparam int unsigned IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam int unsigned WW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [IW-1:0]      IVAL_LAST = IW'(INTERVAL - 1);
    localparam logic [WW-1:0]      WAIT_LOAD = WW'(READ_LAT - 1);
    localparam logic [ADDRMSB:0]   PTR_LAST  = '1;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRd,
        StWait,
        StChk,
        StWb
    } state_e;

    state_e             state_q;
    logic [IW-1:0]      ival_q;
    logic [WW-1:0]      wait_q;
    logic [ADDRMSB:0]   ptr_q;
    logic               req_q;
    logic [ADDRMSB:0]   mem_addr_q;
    logic               mem_we_q;
    logic [127:0]       mem_wdata_q;
    logic [15:0]        sb_q;
    logic [15:0]        db_q;
    logic [ADDRMSB:0]   db_addr_q;
    logic               db_irq_q;
    logic               pass_done_q;

    logic               db_hit;
    logic               sb_inc;
    logic               line_done;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Line outcomes only count while the port is still granted; otherwise the line is abandoned.
    always_comb begin
        db_hit    = bus.gnt && (state_q == StChk) && bus.mem_dberr;
        sb_inc    = bus.gnt && (state_q == StWb);
        line_done = db_hit || sb_inc ||
                    (bus.gnt && (state_q == StChk) && !bus.mem_sberr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            ival_q      <= '0;
            wait_q      <= '0;
            ptr_q       <= '0;
            req_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            sb_q        <= '0;
            db_q        <= '0;
            db_addr_q   <= '0;
            db_irq_q    <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            db_irq_q    <= 1'b0;
            pass_done_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (!enable) begin
                        ival_q <= '0;
                    end else if (ival_q == IVAL_LAST) begin
                        ival_q  <= '0;
                        req_q   <= 1'b1;
                        state_q <= StReq;
                    end else begin
                        ival_q <= ival_q + 1'b1;
                    end
                end
                StReq: begin
                    if (bus.gnt) begin
                        mem_addr_q <= ptr_q;
                        state_q    <= StRd;
                    end
                end
                StRd: begin
                    if (!bus.gnt) begin
                        state_q <= StReq;
                    end else if (READ_LAT == 1) begin
                        state_q <= StChk;
                    end else begin
                        wait_q  <= WAIT_LOAD;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    wait_q <= wait_q - 1'b1;
                    if (!bus.gnt) begin
                        state_q <= StReq;
                    end else if (wait_q == WW'(1)) begin
                        state_q <= StChk;
                    end
                end
                StChk: begin
                    if (!bus.gnt) begin
                        state_q <= StReq;
                    end else if (!bus.mem_dberr && bus.mem_sberr) begin
                        mem_wdata_q <= bus.mem_rdata;
                        mem_we_q    <= 1'b1;
                        state_q     <= StWb;
                    end
                end
                StWb: begin
                    mem_we_q <= 1'b0;
                    if (!bus.gnt) begin
                        state_q <= StReq;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (db_hit) begin
                db_q      <= sat_inc(db_q);
                db_addr_q <= ptr_q;
                db_irq_q  <= 1'b1;
            end
            if (sb_inc) begin
                sb_q <= sat_inc(sb_q);
            end
            if (line_done) begin
                ptr_q       <= ptr_q + 1'b1;
                pass_done_q <= (ptr_q == PTR_LAST);
                req_q       <= 1'b0;
                state_q     <= StIdle;
            end
            // Clear is last so it overrides a same-cycle increment.
            if (clr_counts) begin
                sb_q <= '0;
                db_q <= '0;
            end
        end
    end

    assign bus.req       = req_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign sb_count      = sb_q;
    assign db_count      = db_q;
    assign db_addr       = db_addr_q;
    assign db_irq        = db_irq_q;
    assign pass_done     = pass_done_q;

endmodule
